serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor that computes `a - b` one bit per clock, LSB first. A single full-subtractor cell (two half subtractors plus an OR) works on one bit at a time, and a registered borrow carries between bits. It sits directly downstream of the half-subtractor cell, consuming its `diff`/`bor` behaviour. It gives the datapath a small-area multi-bit subtractor with a start/done handshake.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 1.

Ports:
- `clk`  input  1: the single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: request to begin; sampled only in IDLE.
- `a`  input  WIDTH: minuend; captured on the accepted start edge.
- `b`  input  WIDTH: subtrahend; captured on the accepted start edge.
- `busy`  output  1: high while a subtraction is in progress.
- `done`  output  1: one-cycle pulse when the result is valid.
- `diff`  output  WIDTH: `a - b` modulo 2^WIDTH; holds its value until the next completion.
- `bor`  output  1: final borrow; 1 when `a < b` (unsigned).

## Operation
- Reset (asynchronous, `rst_n=0`):
  - state = IDLE; `busy`, `done`, `diff`, `bor` = 0.
  - Internal shift registers, borrow flop and bit counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - `start=1` latches `a` into `sa` and `b` into `sb`, clears the borrow flop and counter, and moves to SHIFT.
  - `start=0` stays in IDLE.
- SHIFT, once per cycle:
  - Bit equations, with `bin` the borrow flop: `d = sa[0]^sb[0]^bin`; `bout = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bin)`.
  - `d` shifts into the MSB of the internal result register `sr`; `sa` and `sb` shift right; borrow flop ← `bout`; counter increments.
  - When the counter reaches WIDTH-1 during this update, go to DONE and load `diff ← final sr` and `bor ← bout`.
- DONE:
  - `done=1` for exactly one cycle, then IDLE.
  - `start` asserted during DONE is ignored; it must be held or re-asserted in IDLE.
- `start` asserted during SHIFT is ignored; there is no queuing.
- `a` and `b` may change freely after the start edge without affecting the running operation.
- Arithmetic is unsigned, modulo 2^WIDTH. `bor` is the borrow out of the MSB.
- Reset mid-operation aborts immediately. `diff` and `bor` go to 0, and no `done` is produced.

## Timing
- Let E0 be the edge that samples `start=1` in IDLE.
- `busy`: rises after E0; falls after edge E0+WIDTH.
- `done`: high during the cycle following edge E0+WIDTH, i.e. latency WIDTH cycles from E0 to the `done` edge.
- `diff`/`bor`: update on the same edge that raises `done`; stable afterwards until the next completion.
- The earliest next accepted start is edge E0+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- `WIDTH=1`: one SHIFT cycle; `done` follows edge E0+1.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `subtractor_pkg`:
  - state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - counter width function, `$clog2(WIDTH)` with a minimum of 1.
- Sub-module `full_subtractor`:
  - ports `a`, `b`, `bin`, `diff`, `bout`;
  - built from two `halfsubtractor` instances, with `bout` = OR of the two borrows;
  - instantiated once in `serial_subtractor`.
- The top level holds the FSM, counter, operand shift registers, borrow flop and output registers.

## Test plan
- **Basic subtraction:** WIDTH=8, reset, `a=8'h35`, `b=8'h12`, one-cycle `start` → `done` 8 cycles later, `diff=8'h23`, `bor=0`, `busy` high for exactly 8 cycles.
- **Negative result:** `a=8'h12`, `b=8'h35` → `diff=8'hDD`, `bor=1`.
- **Borrow ripple and equality:** `a=8'h00`, `b=8'h01` → `diff=8'hFF`, `bor=1`; then `a=8'hFF`, `b=8'hFF` → `diff=8'h00`, `bor=0`.
- **Start while busy:** start `8'h50-8'h20`; pulse `start` with `8'h01-8'h01` at cycle 3 → only one `done`, `diff=8'h30`; the second operation does not run until `start` is re-asserted in IDLE.
- **Reset mid-operation:** drop `rst_n` for 1 cycle at cycle 4 of `8'h80-8'h01` → `busy`, `done`, `diff`, `bor` go to 0 asynchronously; no `done` pulse; next start `8'h80-8'h01` → `diff=8'h7F`, `bor=0`.
- **Minimum width:** WIDTH=1, exhaustive `a`,`b` ∈ {0,1} → `diff=a^b`, `bor=~a&b`, `done` one cycle after the start edge.

Source files
------------

// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter sizing helper.
package subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A one-bit operand still needs a one-bit counter, so never return zero.
    function automatic int cnt_width(input int w);
        if (w <= 1) begin
            return 1;
        end else begin
            return $clog2(w);
        end
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Full-subtractor cell built from two half subtractors; the borrow out is
// the OR of the two partial borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic d1_s;
    logic b1_s;
    logic b2_s;

    halfsubtractor u_hs_ab (
        .a    (a),
        .b    (b),
        .diff (d1_s),
        .bor  (b1_s)
    );

    halfsubtractor u_hs_bin (
        .a    (d1_s),
        .b    (bin),
        .diff (diff),
        .bor  (b2_s)
    );

    assign bout = b1_s | b2_s;

endmodule

// File: rtl/halfsubtractor.sv
// Half-subtractor cell: single-bit a - b with borrow out.
module halfsubtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic bor
);

    assign diff = a ^ b;
    assign bor  = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB
// first, through a single full-subtractor cell and a registered borrow.
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bor
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_s;
    logic [CW-1:0]    cnt_r;
    logic             bin_r;
    logic             d_s;
    logic             bout_s;
    logic             last_s;
    logic             busy_s;
    logic             done_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             bor_r;

    full_subtractor u_fs (
        .a    (sa_r[0]),
        .b    (sb_r[0]),
        .bin  (bin_r),
        .diff (d_s),
        .bout (bout_s)
    );

    assign last_s = (cnt_r == LAST);
    // Concatenate-then-shift so the expression also holds for WIDTH=1.
    assign sr_s   = WIDTH'({d_s, sr_r} >> 1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode, computed one cycle early so the ports come from flops.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        if (state_s == SHIFT) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
        if ((state_r == SHIFT) && last_s) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // Operand shift registers, partial result, borrow flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_r  <= '0;
            sb_r  <= '0;
            sr_r  <= '0;
            cnt_r <= '0;
            bin_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sa_r  <= a;
                        sb_r  <= b;
                        sr_r  <= '0;
                        cnt_r <= '0;
                        bin_r <= 1'b0;
                    end else begin
                        sa_r  <= sa_r;
                        sb_r  <= sb_r;
                        sr_r  <= sr_r;
                        cnt_r <= cnt_r;
                        bin_r <= bin_r;
                    end
                end
                SHIFT: begin
                    sa_r  <= sa_r >> 1;
                    sb_r  <= sb_r >> 1;
                    sr_r  <= sr_s;
                    cnt_r <= cnt_r + ONE;
                    bin_r <= bout_s;
                end
                default: begin
                    sa_r  <= sa_r;
                    sb_r  <= sb_r;
                    sr_r  <= sr_r;
                    cnt_r <= cnt_r;
                    bin_r <= bin_r;
                end
            endcase
        end
    end

    // Registered handshake and result; result only changes on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            diff_r <= '0;
            bor_r  <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
            if (done_s) begin
                diff_r <= sr_s;
                bor_r  <= bout_s;
            end else begin
                diff_r <= diff_r;
                bor_r  <= bor_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bor  = bor_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

    logic       clk;
    logic       rst8_n;
    logic       rst1_n;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bor8;
    logic       start1;
    logic       a1;
    logic       b1;
    logic       busy1;
    logic       done1;
    logic       diff1;
    logic       bor1;

    int errors;
    int checks;
    int done_cnt8;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bor   (bor8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bor   (bor1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done8) done_cnt8 <= done_cnt8 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 operation: start pulse, then latency, busy length, result.
    task automatic do_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ed, input logic eb);
        int k;
        int busy_cnt;
        @(negedge clk);
        a8 = ia; b8 = ib; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~ia; b8 = ~ib;
        k = 0; busy_cnt = 0;
        while (done8 !== 1'b1 && k < 40) begin
            if (busy8 === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_latency"}, k, 8);
        chk({tag, "_busycycles"}, busy_cnt, 8);
        chk({tag, "_diff"}, diff8, ed);
        chk({tag, "_bor"}, bor8, eb);
        @(posedge clk); #1;
        chk({tag, "_donepulse"}, done8, 1'b0);
        chk({tag, "_diffhold"}, diff8, ed);
    endtask

    initial begin
        errors = 0; checks = 0; done_cnt8 = 0;
        rst8_n = 1'b0; rst1_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_diff", diff8, 8'h00);
        chk("rst_bor", bor8, 1'b0);
        @(negedge clk);
        rst8_n = 1'b1; rst1_n = 1'b1;

        do_op("basic", 8'h35, 8'h12, 8'h23, 1'b0);
        do_op("neg",   8'h12, 8'h35, 8'hDD, 1'b1);
        do_op("ripple", 8'h00, 8'h01, 8'hFF, 1'b1);
        do_op("equal", 8'hFF, 8'hFF, 8'h00, 1'b0);

        // Start while busy: the second request must be dropped.
        @(negedge clk);
        done_cnt8 = 0;
        a8 = 8'h50; b8 = 8'h20; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (16) @(negedge clk);
        chk("busystart_dones", done_cnt8, 1);
        chk("busystart_diff", diff8, 8'h30);
        chk("busystart_bor", bor8, 1'b0);
        chk("busystart_idle", busy8, 1'b0);

        // Reset in the middle of an operation aborts it.
        @(negedge clk);
        done_cnt8 = 0;
        a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("midop_busy", busy8, 1'b1);
        rst8_n = 1'b0;
        #1;
        chk("abort_busy", busy8, 1'b0);
        chk("abort_done", done8, 1'b0);
        chk("abort_diff", diff8, 8'h00);
        chk("abort_bor", bor8, 1'b0);
        @(negedge clk);
        rst8_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_nodone", done_cnt8, 0);
        chk("abort_idle", busy8, 1'b0);
        do_op("after_rst", 8'h80, 8'h01, 8'h7F, 1'b0);

        // WIDTH=1 exhaustive.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            v = i[1:0];
            @(negedge clk);
            a1 = v[1]; b1 = v[0]; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            chk("w1_busy", busy1, 1'b1);
            chk("w1_early", done1, 1'b0);
            @(posedge clk); #1;
            chk("w1_done", done1, 1'b1);
            chk("w1_diff", diff1, v[1] ^ v[0]);
            chk("w1_bor", bor1, ~v[1] & v[0]);
            chk("w1_busyoff", busy1, 1'b0);
            @(posedge clk); #1;
            chk("w1_donepulse", done1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
